// File: rtl/seq_multiplier_pkg.sv
// Shared state encoding, default operand width and a bit-length helper for seq_multiplier.
// Build option SEQ_MULTIPLIER_SIGNED_EN adds the FIX state used for the registered sign fix-up.
package seq_multiplier_pkg;

  localparam int SEQ_MUL_WIDTH_DEF = 4;

`ifdef SEQ_MULTIPLIER_SIGNED_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_FIX  = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;
`endif

  // Position of the highest set bit plus one; 0 for a zero value.
  function automatic int bit_len(input logic [63:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) n = i + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Start/ack request bus of seq_multiplier: operands in, product and status out.
interface seq_multiplier_if #(
  parameter int WIDTH = 4
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2*WIDTH-1:0] rezultat;
  logic               ack;
  logic               busy;

  modport master (output start, a, b, input rezultat, ack, busy);
  modport slave  (input start, a, b, output rezultat, ack, busy);
endinterface

// File: rtl/seq_mul_sign_adapt.sv
// Combinational sign helper: operand magnitudes at accept, conditional negation at completion.
// Only compiled when SEQ_MULTIPLIER_SIGNED_EN is defined.
`ifdef SEQ_MULTIPLIER_SIGNED_EN
module seq_mul_sign_adapt #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic               neg_i,
  output logic [WIDTH-1:0]   a_mag_o,
  output logic [WIDTH-1:0]   b_mag_o,
  output logic               neg_o,
  output logic [2*WIDTH-1:0] res_o
);
  // The most negative value negates to itself, which read unsigned is its magnitude.
  assign a_mag_o = a_i[WIDTH-1] ? -a_i : a_i;
  assign b_mag_o = b_i[WIDTH-1] ? -b_i : b_i;
  assign neg_o   = a_i[WIDTH-1] ^ b_i[WIDTH-1];
  assign res_o   = neg_i ? -acc_i : acc_i;
endmodule
`endif

// File: rtl/seq_multiplier.sv
// Shift-add multiplier, one step per set-or-clear bit of b up to its bit length; ack pulses one cycle.
// Build option SEQ_MULTIPLIER_SIGNED_EN enables two's-complement operands with a registered fix-up.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = SEQ_MUL_WIDTH_DEF
) (
  input logic           Clk,
  input logic           Rst,
  seq_multiplier_if.slave bus
);
  localparam int PW = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [PW-1:0]    x_q, x_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    rez_q, rez_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] a_lat, b_lat;
  logic             accept;

`ifdef SEQ_MULTIPLIER_SIGNED_EN
  logic          neg_q, neg_d;
  logic          neg_new;
  logic [PW-1:0] res_fix;

  seq_mul_sign_adapt #(.WIDTH(WIDTH)) u_sign (
    .a_i     (bus.a),
    .b_i     (bus.b),
    .acc_i   (acc_q),
    .neg_i   (neg_q),
    .a_mag_o (a_lat),
    .b_mag_o (b_lat),
    .neg_o   (neg_new),
    .res_o   (res_fix)
  );
`else
  assign a_lat = bus.a;
  assign b_lat = bus.b;
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    rez_d   = rez_q;
    accept  = 1'b0;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
    neg_d   = neg_q;
`endif
    case (state_q)
      ST_IDLE: accept = bus.start;
      ST_RUN: begin
        if (y_q == '0) begin
`ifdef SEQ_MULTIPLIER_SIGNED_EN
          state_d = ST_FIX;
`else
          state_d = ST_DONE;
          rez_d   = acc_q;
`endif
        end else begin
          if (y_q[0]) acc_d = acc_q + x_q;
          x_d = x_q << 1;
          y_d = y_q >> 1;
        end
      end
`ifdef SEQ_MULTIPLIER_SIGNED_EN
      ST_FIX: begin
        rez_d   = res_fix;
        state_d = ST_DONE;
      end
`endif
      // The DONE exit edge doubles as the first IDLE sample, so a held start
      // yields one result every n+2 cycles.
      ST_DONE: begin
        state_d = ST_IDLE;
        accept  = bus.start;
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      state_d = ST_RUN;
      x_d     = {{WIDTH{1'b0}}, a_lat};
      y_d     = b_lat;
      acc_d   = '0;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
      neg_d   = neg_new;
`endif
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      rez_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      rez_q   <= rez_d;
    end
  end

`ifdef SEQ_MULTIPLIER_SIGNED_EN
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) neg_q <= 1'b0;
    else     neg_q <= neg_d;
  end
`endif

  assign bus.rezultat = rez_q;
  assign bus.ack      = (state_q == ST_DONE);
  assign bus.busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at WIDTH=4; signed vectors replace unsigned ones under SEQ_MULTIPLIER_SIGNED_EN.
module tb_seq_multiplier;

  logic Clk;
  logic Rst;
  int   tests;
  int   failed;
  int   cnt;

  seq_multiplier_if #(.WIDTH(4)) bus ();

  seq_multiplier #(.WIDTH(4)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ack();
    while (!bus.ack && cnt < 20) begin
      @(posedge Clk);
      #1;
      cnt++;
    end
  endtask

  // Full request: accept edge, bounded wait for ack, then the idle cycle after it.
  task automatic run_op(input string tag, input logic [3:0] av, input logic [3:0] bv,
                        input int exp_lat, input logic [7:0] exp_rez);
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    @(posedge Clk);
    #1;
    bus.start = 1'b0;
    check({tag, "_busy_up"}, 32'(bus.busy), 32'd1);
    cnt = 0;
    wait_ack();
    check({tag, "_latency"}, 32'(cnt), 32'(exp_lat));
    check({tag, "_rez"}, 32'(bus.rezultat), 32'(exp_rez));
    @(posedge Clk);
    #1;
    check({tag, "_ack_down"}, 32'(bus.ack), 32'd0);
    check({tag, "_busy_down"}, 32'(bus.busy), 32'd0);
    check({tag, "_rez_hold"}, 32'(bus.rezultat), 32'(exp_rez));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests     = 0;
    failed    = 0;
    Rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_rez", 32'(bus.rezultat), 32'd0);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    Rst = 1'b0;
    @(posedge Clk);
    #1;

`ifdef SEQ_MULTIPLIER_SIGNED_EN
    run_op("s_m8xm8", 4'h8, 4'h8, 6, 8'h40);
    run_op("s_m3x5", 4'hD, 4'h5, 5, 8'hF1);
    run_op("s_7xm1", 4'h7, 4'hF, 3, 8'hF9);
`else
    run_op("u_12x6", 4'd12, 4'd6, 4, 8'd72);
    run_op("u_15x15", 4'd15, 4'd15, 5, 8'd225);
    run_op("u_9x0", 4'd9, 4'd0, 1, 8'd0);

    // Operand and start changes during RUN must not disturb the 10x7 product.
    bus.a     = 4'd10;
    bus.b     = 4'd7;
    bus.start = 1'b1;
    @(posedge Clk);
    #1;
    bus.start = 1'b0;
    @(posedge Clk);
    #1;
    bus.a     = 4'd1;
    bus.b     = 4'd1;
    bus.start = 1'b1;
    @(posedge Clk);
    #1;
    bus.start = 1'b0;
    cnt = 2;
    wait_ack();
    check("run_ignore_latency", 32'(cnt), 32'd4);
    check("run_ignore_rez", 32'(bus.rezultat), 32'd70);
    @(posedge Clk);
    #1;
    check("run_ignore_busy", 32'(bus.busy), 32'd0);
    @(posedge Clk);
    #1;
    check("run_ignore_no_reaccept", 32'(bus.busy), 32'd0);

    // Held start: 3x5 repeats every 5 cycles.
    bus.a     = 4'd3;
    bus.b     = 4'd5;
    bus.start = 1'b1;
    @(posedge Clk);
    #1;
    cnt = 0;
    wait_ack();
    check("b2b_first_latency", 32'(cnt), 32'd4);
    check("b2b_first_rez", 32'(bus.rezultat), 32'd15);
    for (int k = 0; k < 2; k++) begin
      cnt = 0;
      do begin
        @(posedge Clk);
        #1;
        cnt++;
      end while (!bus.ack && cnt < 20);
      check("b2b_period", 32'(cnt), 32'd5);
      check("b2b_rez", 32'(bus.rezultat), 32'd15);
    end
    bus.start = 1'b0;
    @(posedge Clk);
    #1;
    check("b2b_stop_busy", 32'(bus.busy), 32'd0);

    // Asynchronous reset in the middle of a 12x6 run.
    bus.a     = 4'd12;
    bus.b     = 4'd6;
    bus.start = 1'b1;
    @(posedge Clk);
    #1;
    bus.start = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    #1;
    check("midrst_rez", 32'(bus.rezultat), 32'd0);
    check("midrst_ack", 32'(bus.ack), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    #1;
    Rst = 1'b0;
    @(posedge Clk);
    #1;
    check("midrst_idle", 32'(bus.busy), 32'd0);
    run_op("u_2x3", 4'd2, 4'd3, 3, 8'd6);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
